// File: rtl/tpu_pkg.sv
// Shared types and constants for the operand-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpu_pkg;

    // The grant state doubles as the grant register: which requester owns the bus.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    // Encoding of out_src / sel / last_served.
    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage

// File: rtl/tpu_operand_arbiter_if.sv
// Bundle of requester A/B, shared-bus and status signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both upstream ports and on the downstream port.
interface tpu_operand_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_last;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_last;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;
    logic              sel;
    logic              busy;

    // Environment side: requesters plus downstream sink.
    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, sel, busy
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, sel, busy
    );
endinterface

// File: rtl/tpu_rr_pick.sv
// Round-robin winner between A and B given who was served last.
// Latency: combinational.
// Backpressure: none; pure decision logic.
module tpu_rr_pick
    import tpu_pkg::*;
(
    input  logic a_vld,
    input  logic b_vld,
    input  logic last_served,
    output logic pick_vld,
    output logic pick_src
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_vld = a_vld | b_vld;
        pick_src = SRC_B;
        if (a_vld && b_vld) begin
            pick_src = (last_served == SRC_A) ? SRC_B : SRC_A;
        end else if (a_vld) begin
            pick_src = SRC_A;
        end
    end

endmodule

// File: rtl/tpu_operand_arbiter.sv
// Round-robin burst arbiter sharing one operand bus between requesters A and B (ARB_PERF_CNT_EN adds grant counters).
// Latency: data path combinational (0 cycles); grant registered, first beat one cycle after the request.
// Backpressure: out_ready passes straight to the granted requester's ready; the other requester sees ready=0.
module tpu_operand_arbiter
    import tpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    tpu_operand_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     gnt_cnt_a,
    output logic [CNT_W-1:0]     gnt_cnt_b
`endif
);

    localparam int              BEAT_W   = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                last_served_q, last_served_d;
    logic                sel_q, sel_d;

    logic                busy_w;
    logic                x_vld;
    logic                x_last;
    logic                beat;
    logic                grant_end;
    logic                end_a_vld;
    logic                end_b_vld;
    logic                idle_pick_vld, idle_pick_src;
    logic                end_pick_vld, end_pick_src;
    logic [DATA_W-1:0]   mux_dat;

    // Steer the granted requester's control onto shared signals and detect the closing beat.
    always_comb begin
        busy_w    = (state_q != IDLE);
        x_vld     = (sel_q == SRC_A) ? bus.a_valid : bus.b_valid;
        x_last    = (sel_q == SRC_A) ? bus.a_last  : bus.b_last;
        beat      = busy_w & x_vld & bus.out_ready;
        grant_end = beat & (x_last | ((beat_cnt_q + BEAT_W'(1)) == BEAT_MAX));
        // A valid that carried a last beat belongs to the finished burst, so it
        // cannot ask for a fresh grant; a truncated burst still wants more.
        end_a_vld = bus.a_valid & ~((sel_q == SRC_A) & bus.a_last);
        end_b_vld = bus.b_valid & ~((sel_q == SRC_B) & bus.b_last);
    end

    tpu_rr_pick u_pick_idle (
        .a_vld       (bus.a_valid),
        .b_vld       (bus.b_valid),
        .last_served (last_served_q),
        .pick_vld    (idle_pick_vld),
        .pick_src    (idle_pick_src)
    );

    // At a grant end the owner becomes last_served, so the other side wins any tie.
    tpu_rr_pick u_pick_end (
        .a_vld       (end_a_vld),
        .b_vld       (end_b_vld),
        .last_served (sel_q),
        .pick_vld    (end_pick_vld),
        .pick_src    (end_pick_src)
    );

    // Next grant, beat count and round-robin pointer.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (idle_pick_vld) begin
                    state_d = (idle_pick_src == SRC_A) ? GNT_A : GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (grant_end) begin
                    beat_cnt_d    = '0;
                    last_served_d = sel_q;
                    if (end_pick_vld) begin
                        state_d = (end_pick_src == SRC_A) ? GNT_A : GNT_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d = sel_q;
        if (state_d == GNT_A) begin
            sel_d = SRC_A;
        end else if (state_d == GNT_B) begin
            sel_d = SRC_B;
        end
    end

    // Control state register; reset leaves A first in line and the mux pointing at A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            last_served_q <= SRC_B;
            sel_q         <= SRC_A;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_served_q <= last_served_d;
            sel_q         <= sel_d;
        end
    end

    assign mux_dat       = (sel_q == SRC_A) ? bus.a_data : bus.b_data;
    assign bus.out_data  = busy_w ? mux_dat : '0;
    assign bus.out_valid = busy_w & x_vld;
    assign bus.out_src   = busy_w & (sel_q == SRC_A);
    assign bus.a_ready   = busy_w & (sel_q == SRC_A) & bus.out_ready;
    assign bus.b_ready   = busy_w & (sel_q == SRC_B) & bus.out_ready;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_w;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] gnt_cnt_a_q, gnt_cnt_a_d;
    logic [CNT_W-1:0] gnt_cnt_b_q, gnt_cnt_b_d;

    // Saturating completed-grant counters; a clear beats a same-cycle increment.
    always_comb begin
        gnt_cnt_a_d = gnt_cnt_a_q;
        gnt_cnt_b_d = gnt_cnt_b_q;
        if (cnt_clr) begin
            gnt_cnt_a_d = '0;
            gnt_cnt_b_d = '0;
        end else if (grant_end) begin
            if (sel_q == SRC_A) begin
                if (~&gnt_cnt_a_q) gnt_cnt_a_d = gnt_cnt_a_q + CNT_W'(1);
            end else begin
                if (~&gnt_cnt_b_q) gnt_cnt_b_d = gnt_cnt_b_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt_a_q <= '0;
            gnt_cnt_b_q <= '0;
        end else begin
            gnt_cnt_a_q <= gnt_cnt_a_d;
            gnt_cnt_b_q <= gnt_cnt_b_d;
        end
    end

    assign gnt_cnt_a = gnt_cnt_a_q;
    assign gnt_cnt_b = gnt_cnt_b_q;
`endif

endmodule

// File: tb/tb_tpu_operand_arbiter.sv
// Bench for tpu_operand_arbiter: directed table, corner-case sequences, random traffic vs. a reference model.
// Latency: n/a.
// Backpressure: random out_ready in the random phase.
module tb_tpu_operand_arbiter;

    localparam int BL = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tpu_operand_arbiter_if #(.DATA_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    logic          cnt_clr;
    logic [CW-1:0] gnt_cnt_a, gnt_cnt_b;
    int            m_cnt_a, m_cnt_b;
`endif

    tpu_operand_arbiter #(
        .DATA_W    (DW),
        .BURST_LEN (BL)
`ifdef ARB_PERF_CNT_EN
        ,
        .CNT_W     (CW)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .gnt_cnt_a (gnt_cnt_a),
        .gnt_cnt_b (gnt_cnt_b)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: who owns the bus (0 none, 1 A, 2 B), beats granted so far,
    // who finished the most recent grant, and the remembered mux select.
    int m_owner;
    int m_beats;
    int m_prev;
    bit m_sel;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic al, input logic [31:0] ad,
                         input logic bv, input logic bl, input logic [31:0] bd, input logic ordy);
        rst           = r;
        bus.a_valid   = av;
        bus.a_last    = al;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_last    = bl;
        bus.b_data    = bd;
        bus.out_ready = ordy;
    endtask

    function automatic logic [5:0] got_flags();
        return {bus.a_ready, bus.b_ready, bus.out_valid, bus.out_src, bus.sel, bus.busy};
    endfunction

    // Wait for the falling edge and compare every output with the model.
    task automatic settle();
        logic [5:0]  ef;
        logic [31:0] ed;
        @(negedge clk);
        if (m_owner == 0) begin
            ef = {5'b00000, 1'b0};
            ef[1] = m_sel;
            ed = '0;
        end else if (m_owner == 1) begin
            ef = {bus.out_ready, 1'b0, bus.a_valid, 1'b1, m_sel, 1'b1};
            ed = bus.a_data;
        end else begin
            ef = {1'b0, bus.out_ready, bus.b_valid, 1'b0, m_sel, 1'b1};
            ed = bus.b_data;
        end
        chk("model", {26'd0, got_flags(), bus.out_data}, {26'd0, ef, ed});
`ifdef ARB_PERF_CNT_EN
        chk("model_cnt", {60'd0, gnt_cnt_a, gnt_cnt_b}, {60'd0, CW'(m_cnt_a), CW'(m_cnt_b)});
`endif
    endtask

    // Advance the model by the rules of a grant, then let the clock edge happen.
    task automatic cycle_end();
        bit xv, xl, oth;
        if (rst) begin
            m_owner = 0;
            m_beats = 0;
            m_prev  = 2;
            m_sel   = 1'b1;
`ifdef ARB_PERF_CNT_EN
            m_cnt_a = 0;
            m_cnt_b = 0;
`endif
        end else begin
            if (m_owner == 0) begin
                if (bus.a_valid && bus.b_valid) m_owner = (m_prev == 1) ? 2 : 1;
                else if (bus.a_valid)           m_owner = 1;
                else if (bus.b_valid)           m_owner = 2;
            end else begin
                xv  = (m_owner == 1) ? bus.a_valid : bus.b_valid;
                xl  = (m_owner == 1) ? bus.a_last  : bus.b_last;
                oth = (m_owner == 1) ? bus.b_valid : bus.a_valid;
                if (xv && bus.out_ready) begin
                    m_beats++;
                    if (xl || m_beats == BL) begin
`ifdef ARB_PERF_CNT_EN
                        if (m_owner == 1 && m_cnt_a < CMAX) m_cnt_a++;
                        if (m_owner == 2 && m_cnt_b < CMAX) m_cnt_b++;
`endif
                        m_prev  = m_owner;
                        m_beats = 0;
                        if (oth)      m_owner = 3 - m_owner;
                        else if (xl)  m_owner = 0;
                    end
                end
            end
            if (m_owner != 0) m_sel = (m_owner == 1);
`ifdef ARB_PERF_CNT_EN
            if (cnt_clr) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic        rst, av, al;
        logic [31:0] ad;
        logic        bv, ordy;
        logic [5:0]  ef;   // {a_ready, b_ready, out_valid, out_src, sel, busy}
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[12];

    localparam logic [31:0] BD = 32'hB000_0000;

    initial begin
        int a_n, b_n;
        logic exp_src;

        // Reset held with both requesters valid, release, then a 6-beat A stream
        // that is cut after 4 beats and regranted without a bubble.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b1, 6'b000010, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b1, 6'b000010, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b1, 6'b000010, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0001, 1'b0, 1'b0, 6'b001111, 32'hA000_0001};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0001, 1'b0, 1'b1, 6'b101111, 32'hA000_0001};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0002, 1'b0, 1'b1, 6'b101111, 32'hA000_0002};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0003, 1'b0, 1'b1, 6'b101111, 32'hA000_0003};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0004, 1'b0, 1'b1, 6'b101111, 32'hA000_0004};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'hA000_0005, 1'b0, 1'b1, 6'b101111, 32'hA000_0005};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'hA000_0006, 1'b0, 1'b1, 6'b101111, 32'hA000_0006};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'hA000_0007, 1'b0, 1'b1, 6'b000010, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'hA000_0007, 1'b0, 1'b1, 6'b000010, 32'h0};

`ifdef ARB_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        m_owner = 0; m_beats = 0; m_prev = 2; m_sel = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b0, BD, 1'b1);
        cycle_end();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].al, tbl[i].ad, tbl[i].bv, 1'b0, BD, tbl[i].ordy);
            settle();
            chk($sformatf("tbl%0d_flags", i), {58'd0, got_flags()}, {58'd0, tbl[i].ef});
            chk($sformatf("tbl%0d_data", i), {32'd0, bus.out_data}, {32'd0, tbl[i].ed});
            cycle_end();
        end

        // Both stream back to back, bursts of 2: sources alternate in pairs with no gaps.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, BD, 1'b1);
        settle(); cycle_end();
        a_n = 0; b_n = 0;
        for (int k = 0; k < 13; k++) begin
            drive(1'b0, 1'b1, (a_n % 2 == 1), 32'hA100_0000 + k, 1'b1, (b_n % 2 == 1), BD + k, 1'b1);
            settle();
            if (k >= 1) begin
                exp_src = (((k - 1) / 2) % 2 == 0);
                chk("t3_src", {62'd0, bus.out_valid, bus.out_src}, {62'd0, 1'b1, exp_src});
            end
            if (bus.a_ready) a_n++;
            if (bus.b_ready) b_n++;
            cycle_end();
        end

        // A stalls mid-burst with B waiting: grant held, B gets the cycle after A's last beat.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, BD, 1'b1);
        settle(); cycle_end();
        drive(1'b0, 1'b1, 1'b0, 32'hA200_0001, 1'b0, 1'b0, BD, 1'b1);
        settle(); cycle_end();
        drive(1'b0, 1'b1, 1'b0, 32'hA200_0001, 1'b1, 1'b0, BD, 1'b1);
        settle();
        chk("t4_a_beat", {63'd0, bus.a_ready}, 64'd1);
        cycle_end();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'hA200_0002, 1'b1, 1'b0, BD, 1'b1);
            settle();
            chk("t4_hold", {60'd0, bus.b_ready, bus.busy, bus.sel, bus.out_valid}, {60'd0, 4'b0110});
            cycle_end();
        end
        drive(1'b0, 1'b1, 1'b1, 32'hA200_0002, 1'b1, 1'b0, 32'hB200_0001, 1'b1);
        settle();
        chk("t4_a_last", {62'd0, bus.a_ready, bus.out_src}, {62'd0, 2'b11});
        cycle_end();
        drive(1'b0, 1'b1, 1'b0, 32'hA300_0001, 1'b1, 1'b0, 32'hB200_0001, 1'b1);
        settle();
        chk("t4_b_gnt", {61'd0, bus.out_valid, bus.out_src, bus.b_ready}, {61'd0, 3'b101});
        chk("t4_b_data", {32'd0, bus.out_data}, {32'd0, 32'hB200_0001});
        cycle_end();

        // Downstream stall mid-burst: output stable, beat count unchanged, burst length intact.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'hA300_0001, 1'b1, 1'b0, 32'hB200_0002, 1'b0);
            settle();
            chk("t5_stall", {28'd0, bus.out_valid, bus.out_src, bus.b_ready, bus.a_ready, bus.out_data},
                {28'd0, 4'b1000, 32'hB200_0002});
            cycle_end();
        end
        for (int k = 2; k <= 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'hA300_0001, 1'b1, 1'b0, 32'hB200_0000 + k, 1'b1);
            settle();
            chk("t5_b_beat", {62'd0, bus.b_ready, bus.out_src}, {62'd0, 2'b10});
            cycle_end();
        end
        drive(1'b0, 1'b1, 1'b0, 32'hA300_0001, 1'b0, 1'b0, BD, 1'b1);
        settle();
        chk("t5_cnt", {62'd0, bus.out_src, bus.a_ready}, {62'd0, 2'b11});
        cycle_end();

        // Reset at beat 2 of an A burst aborts it.
        drive(1'b1, 1'b1, 1'b0, 32'hA300_0002, 1'b0, 1'b0, BD, 1'b1);
        settle(); cycle_end();
        drive(1'b0, 1'b0, 1'b0, 32'hA300_0003, 1'b0, 1'b0, BD, 1'b1);
        settle();
        chk("t6_idle", {26'd0, got_flags(), bus.out_data}, {26'd0, 6'b000010, 32'h0});
`ifdef ARB_PERF_CNT_EN
        chk("t6_cnt_rst", {60'd0, gnt_cnt_a, gnt_cnt_b}, 64'd0);
`endif
        cycle_end();
        // Single-beat grants: A, B, A, B, A.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 1'b1, 32'hA400_0000 + k, (k < 5), 1'b1, BD + k, 1'b1);
            settle(); cycle_end();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, BD, 1'b1);
        settle();
        chk("t6_idle_after", {63'd0, bus.busy}, 64'd0);
`ifdef ARB_PERF_CNT_EN
        chk("t6_cnt_a", {62'd0, gnt_cnt_a}, 64'd3);
        chk("t6_cnt_b", {62'd0, gnt_cnt_b}, 64'd2);
`endif
        cycle_end();
        // One more A grant with the A counter already at all-ones.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b1, 32'hA500_0000, 1'b0, 1'b0, BD, 1'b1);
            settle(); cycle_end();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, BD, 1'b1);
        settle();
`ifdef ARB_PERF_CNT_EN
        chk("cnt_sat", {62'd0, gnt_cnt_a}, 64'd3);
`endif
        cycle_end();
        // Clear in the same cycle as a grant end.
        drive(1'b0, 1'b1, 1'b1, 32'hA600_0000, 1'b0, 1'b0, BD, 1'b1);
        settle(); cycle_end();
`ifdef ARB_PERF_CNT_EN
        cnt_clr = 1'b1;
`endif
        settle(); cycle_end();
`ifdef ARB_PERF_CNT_EN
        cnt_clr = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, BD, 1'b1);
        settle();
`ifdef ARB_PERF_CNT_EN
        chk("cnt_clr", {60'd0, gnt_cnt_a, gnt_cnt_b}, 64'd0);
`endif
        cycle_end();

        // Random traffic, backpressure and occasional reset against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 3) != 0);
`ifdef ARB_PERF_CNT_EN
            cnt_clr = ($urandom_range(0, 99) < 2);
`endif
            settle();
            cycle_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
